time_frame_ctrl: RTL and testbench
==================================

// Module: time_frame_ctrl
// PURPOSE
//  Sits between the QPSK demodulator frame output and the h/m/s 7-segment display path.
//  Validates each received 40-bit time frame (header, range, optional checksum) and loads good ones into a local clock.
//  Keeps the local clock running at 1 Hz between frames and drives the display word.
//  Reports lock, staleness and error statistics.
// PARAMETERS
//  CLK_FREQ   50_000_000  clk cycles per second; 1 s prescaler terminal count = CLK_FREQ-1
//  HEADER     8'hA5       required frame_dat[39:32]
//  TIMEOUT_S  8'd10       seconds without a valid frame before stale asserts (>=1)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  frame_dat  in   40  {hdr[39:32], h[31:24], m[23:16], s[15:8], chk[7:0]}, binary fields
//  frame_vld  in   1   1-cycle strobe, frame_dat valid
//  time_o     out  40  display word, same layout; feeds the h/m/s display datapath
//  sec_tick   out  1   1-cycle pulse each local second while locked
//  frame_ok   out  1   1-cycle pulse: frame accepted
//  frame_err  out  1   1-cycle pulse: frame rejected
//  locked     out  1   at least one valid frame since reset
//  stale      out  1   TIMEOUT_S seconds elapsed since last accepted frame
//  err_cnt    out  8   rejected-frame count, saturates at 255
// BEHAVIOUR
//  Reset values:
//   - time_o={HEADER,32'h0}; all pulses, locked, stale and err_cnt are 0
//   - FSM in IDLE; prescaler and timeout counter are 0
//  FSM IDLE/CHECK/RUN:
//   - IDLE|RUN --frame_vld--> CHECK; frame_dat captured on the same edge
//   - CHECK --valid--> RUN
//   - CHECK --invalid--> RUN if locked, else IDLE
//   - CHECK is always exactly 1 cycle
//  frame_vld while in CHECK: frame ignored, not counted.
//  Latency: frame_vld sampled on edge E; on edge E+1, time_o, frame_ok/frame_err and err_cnt update.
//  Valid = hdr==HEADER && h<=23 && m<=59 && s<=59 (&& chk ok when FRAME_CHKSUM_EN).
//  Accept action:
//   - load h/m/s; prescaler cleared to 0 (phase aligned to frame)
//   - timeout counter cleared; stale<=0; locked<=1
//  Reject action: err_cnt+1 (hold at 255); time untouched.
//  Local clock, only while locked:
//   - prescaler wraps at CLK_FREQ-1 and issues sec_tick
//   - s 59->0 carries to m; m 59->0 carries to h; h 23->0
//  Same-edge load and tick: load wins; that tick is lost and sec_tick stays 0.
//  Timeout counter:
//   - +1 per sec_tick, saturates at TIMEOUT_S
//   - stale=1 when it reaches TIMEOUT_S; local clock keeps running while stale
//  IDLE: time_o held at 00:00:00, no ticks.
//  Async rst mid-operation: immediate return to reset values; captured frame discarded.
// CONFIGURATION
//  FRAME_CHKSUM_EN defined:
//   - chk must equal (h+m+s) mod 256
//   - time_o[7:0] regenerated as (h+m+s) mod 256 of the displayed time
//  FRAME_CHKSUM_EN undefined:
//   - chk ignored
//   - time_o[7:0]=8'h00
// STRUCTURE
//  Package time_ctrl_pkg:
//   - FSM state enum (IDLE, CHECK, RUN)
//   - H_MAX=23, M_MAX=59, S_MAX=59
//   - field bit positions of the 40-bit frame
//  Sub-module sec_prescaler:
//   - parameter CLK_FREQ; inputs clk, rst, en, clr; output tick
//   - tick is 1 cycle when the count is CLK_FREQ-1 and en=1
//  Remainder (FSM, validation, h/m/s counters, statistics) stays in this block.
// TESTING (CLK_FREQ=10, TIMEOUT_S=3, FRAME_CHKSUM_EN defined unless noted)
//  1 Idle after reset, no frame -> time_o=40'hA5_00_00_00_00; locked=0; no sec_tick in 100 cycles.
//  2 Frame 40'hA5_0A_14_1E_3C -> frame_ok at E+1; time_o=40'hA5_0A_14_1E_3C; locked=1.
//     Same run, 10 cycles later: sec_tick, time_o=40'hA5_0A_14_1F_3D.
//  3 Frame 40'hA5_17_3B_3A_8C (23:59:58), then 2 ticks -> 23:59:59, then 40'hA5_00_00_00_00.
//  4 Rejected frames, time unchanged, err_cnt 1 -> 2 -> 3, frame_err pulsed each:
//     - 40'hA5_0A_14_1E_3D (bad chk)
//     - 40'hA5_18_00_00_18 (h=24)
//     - 40'h5A_0A_14_1E_3C (bad hdr)
//     Same stimulus with FRAME_CHKSUM_EN undefined: first frame accepted.
//  5 Locked, 3 ticks with no frame -> stale=1; next valid frame -> stale=0, prescaler restarts at 0.
//  6 rst pulse mid-RUN, with frame_vld on the edge after release -> all outputs at reset values; that frame still accepted at E+1.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared definitions for the time frame controller.
//   state_e       : controller FSM states
//   H_MAX/M_MAX/S_MAX : largest legal hour/minute/second value
//   *Lsb          : bit positions of the fields in the 40-bit frame
//   hms_sum       : 8-bit checksum of a h/m/s triple
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [7:0] H_MAX = 8'd23;
  localparam logic [7:0] M_MAX = 8'd59;
  localparam logic [7:0] S_MAX = 8'd59;

  localparam int unsigned HdrLsb = 32;
  localparam int unsigned HLsb   = 24;
  localparam int unsigned MLsb   = 16;
  localparam int unsigned SLsb   = 8;
  localparam int unsigned ChkLsb = 0;

  // Wraps modulo 256.
  function automatic logic [7:0] hms_sum(input logic [7:0] h, input logic [7:0] m,
                                         input logic [7:0] s);
    return h + m + s;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable
//   clr      : synchronous clear to 0 (takes priority over en)
//   tick     : high for the cycle in which the count is CLK_FREQ-1 and en=1
module sec_prescaler #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_frame_ctrl.sv
// Time frame controller: validates received 40-bit time frames, loads good ones into a
// local h/m/s clock that runs at 1 Hz, and reports lock/staleness/error statistics.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   frame_dat  : {hdr, h, m, s, chk}; frame_vld : 1-cycle strobe
//   time_o     : display word {HEADER, h, m, s, chk}
//   sec_tick   : 1-cycle pulse per local second while locked
//   frame_ok / frame_err : accept / reject pulses
//   locked, stale, err_cnt : status
// Optional feature: define FRAME_CHKSUM_EN to require chk == (h+m+s) mod 256 and to
// regenerate time_o[7:0] from the displayed time; otherwise chk is ignored and
// time_o[7:0] is zero.
module time_frame_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter logic [7:0]  TIMEOUT_S = 8'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] frame_dat,
  input  logic        frame_vld,
  output logic [39:0] time_o,
  output logic        sec_tick,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        locked,
  output logic        stale,
  output logic [7:0]  err_cnt
);

`ifdef FRAME_CHKSUM_EN
  localparam int unsigned FrmLsb = 0;
`else
  localparam int unsigned FrmLsb = 8;
  logic unused_chk;
  assign unused_chk = ^frame_dat[7:0];
`endif

  state_e          state_q, state_d;
  logic [39:FrmLsb] frm_q, frm_d;
  logic [7:0]      h_q, h_d, m_q, m_d, s_q, s_d;
  logic [7:0]      to_q, to_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            locked_q, locked_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            sec_tick_q, sec_tick_d;
  logic            accept;
  logic            tick;
  logic            frm_valid;

  logic [7:0] f_hdr, f_h, f_m, f_s;
  assign f_hdr = frm_q[HdrLsb +: 8];
  assign f_h   = frm_q[HLsb +: 8];
  assign f_m   = frm_q[MLsb +: 8];
  assign f_s   = frm_q[SLsb +: 8];

  always_comb begin
    frm_valid = (f_hdr == HEADER) && (f_h <= H_MAX) && (f_m <= M_MAX) && (f_s <= S_MAX);
`ifdef FRAME_CHKSUM_EN
    frm_valid = frm_valid && (frm_q[ChkLsb +: 8] == hms_sum(f_h, f_m, f_s));
`endif
  end

  sec_prescaler #(
    .CLK_FREQ(CLK_FREQ)
  ) u_sec_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (locked_q),
    .clr (accept),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    frm_d       = frm_q;
    h_d         = h_q;
    m_d         = m_q;
    s_d         = s_q;
    to_d        = to_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    sec_tick_d  = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (frame_vld) begin
          state_d = CHECK;
          frm_d   = frame_dat[39:FrmLsb];
        end
      end
      CHECK: begin
        if (frm_valid) begin
          accept     = 1'b1;
          state_d    = RUN;
          h_d        = f_h;
          m_d        = f_m;
          s_d        = f_s;
          to_d       = '0;
          locked_d   = 1'b1;
          frame_ok_d = 1'b1;
        end else begin
          state_d     = locked_q ? RUN : IDLE;
          frame_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load on the same edge as a tick wins; that second is dropped.
    if (tick && !accept) begin
      sec_tick_d = 1'b1;
      if (to_q < TIMEOUT_S) begin
        to_d = to_q + 8'd1;
      end
      if (s_q == S_MAX) begin
        s_d = '0;
        if (m_q == M_MAX) begin
          m_d = '0;
          h_d = (h_q == H_MAX) ? 8'd0 : h_q + 8'd1;
        end else begin
          m_d = m_q + 8'd1;
        end
      end else begin
        s_d = s_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frm_q       <= '0;
      h_q         <= '0;
      m_q         <= '0;
      s_q         <= '0;
      to_q        <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sec_tick_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_q       <= frm_d;
      h_q         <= h_d;
      m_q         <= m_d;
      s_q         <= s_d;
      to_q        <= to_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      sec_tick_q  <= sec_tick_d;
    end
  end

`ifdef FRAME_CHKSUM_EN
  assign time_o = {HEADER, h_q, m_q, s_q, hms_sum(h_q, m_q, s_q)};
`else
  assign time_o = {HEADER, h_q, m_q, s_q, 8'h00};
`endif

  assign sec_tick  = sec_tick_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign locked    = locked_q;
  assign stale     = (to_q >= TIMEOUT_S);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_time_frame_ctrl.sv
// Bench for time_frame_ctrl (CLK_FREQ=10, TIMEOUT_S=3). A time-of-day model in seconds
// predicts every output each cycle; directed checks pin literal values.
module tb_time_frame_ctrl;

  localparam int unsigned ClkFreq  = 10;
  localparam logic [7:0]  TimeoutS = 8'd3;
`ifdef FRAME_CHKSUM_EN
  localparam int ChkOn = 1;
`else
  localparam int ChkOn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] frame_dat = '0;
  logic        frame_vld = 1'b0;
  logic [39:0] time_o;
  logic        sec_tick, frame_ok, frame_err, locked, stale;
  logic [7:0]  err_cnt;

  time_frame_ctrl #(
    .CLK_FREQ (ClkFreq),
    .HEADER   (8'hA5),
    .TIMEOUT_S(TimeoutS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_dat(frame_dat),
    .frame_vld(frame_vld),
    .time_o   (time_o),
    .sec_tick (sec_tick),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .locked   (locked),
    .stale    (stale),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Literal display words are written with their checksum byte; without the checksum
  // feature that byte is zero on time_o.
  function automatic logic [39:0] lit(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    if (ChkOn == 0) r[7:0] = 8'h00;
    return r;
  endfunction

  // ---------------- model ----------------
  int          m_tod, m_phase, m_tout, m_err;
  bit          m_locked, m_pend, m_ok, m_ferr, m_tick;
  logic [39:0] m_pdat;

  function automatic bit frame_good(input logic [39:0] d);
    int h, m, s;
    h = int'(d[31:24]);
    m = int'(d[23:16]);
    s = int'(d[15:8]);
    if (d[39:32] != 8'hA5 || h > 23 || m > 59 || s > 59) return 1'b0;
    if (ChkOn != 0 && int'(d[7:0]) != ((h + m + s) % 256)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [39:0] tod_word(input int tod);
    int h, m, s;
    logic [39:0] w;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    w = {8'hA5, 8'(h), 8'(m), 8'(s), 8'h00};
    if (ChkOn != 0) w[7:0] = 8'((h + m + s) % 256);
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int tod, ph, tout, err;
    bit lk, pend, ok, fe, tk, ld;
    logic [39:0] pd;
    if (rst) begin
      m_tod <= 0; m_phase <= 0; m_tout <= 0; m_err <= 0;
      m_locked <= 1'b0; m_pend <= 1'b0; m_ok <= 1'b0; m_ferr <= 1'b0; m_tick <= 1'b0;
      m_pdat <= '0;
    end else begin
      tod = m_tod; ph = m_phase; tout = m_tout; err = m_err;
      lk = m_locked; pend = m_pend; pd = m_pdat;
      ok = 1'b0; fe = 1'b0; tk = 1'b0; ld = 1'b0;
      if (m_pend) begin
        pend = 1'b0;
        if (frame_good(m_pdat)) begin
          ld   = 1'b1;
          ok   = 1'b1;
          lk   = 1'b1;
          tod  = int'(m_pdat[31:24]) * 3600 + int'(m_pdat[23:16]) * 60 + int'(m_pdat[15:8]);
          ph   = 0;
          tout = 0;
        end else begin
          fe = 1'b1;
          if (err < 255) err++;
        end
      end else if (frame_vld) begin
        pend = 1'b1;
        pd   = frame_dat;
      end
      // Seconds fall every ClkFreq edges after the last load.
      if (m_locked && !ld) begin
        ph++;
        if (ph == int'(ClkFreq)) begin
          ph  = 0;
          tk  = 1'b1;
          tod = (tod + 1) % 86400;
          if (tout < int'(TimeoutS)) tout++;
        end
      end
      m_tod <= tod; m_phase <= ph; m_tout <= tout; m_err <= err;
      m_locked <= lk; m_pend <= pend; m_pdat <= pd;
      m_ok <= ok; m_ferr <= fe; m_tick <= tk;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_time_o", time_o, tod_word(m_tod));
      check("cyc_sec_tick", 40'(sec_tick), 40'(m_tick));
      check("cyc_frame_ok", 40'(frame_ok), 40'(m_ok));
      check("cyc_frame_err", 40'(frame_err), 40'(m_ferr));
      check("cyc_locked", 40'(locked), 40'(m_locked));
      check("cyc_stale", 40'(stale), 40'(m_tout >= int'(TimeoutS)));
      check("cyc_err_cnt", 40'(err_cnt), 40'(m_err));
    end
  end

  // Called just after a negedge; returns just after the negedge following E+1.
  task automatic send(input logic [39:0] d);
    frame_dat = d;
    frame_vld = 1'b1;
    @(negedge clk);
    frame_vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_time_o", time_o, 40'hA5_00_00_00_00);
    check("rst_err_cnt", 40'(err_cnt), 40'd0);
    rst = 1'b0;

    // 1: idle, no ticks
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (sec_tick) ticks++;
    end
    check("t1_ticks", 40'(ticks), 40'd0);
    check("t1_time_o", time_o, 40'hA5_00_00_00_00);
    check("t1_locked", 40'(locked), 40'd0);

    // 2: first valid frame, then first second
    send(40'hA5_0A_14_1E_3C);
    check("t2_ok", 40'(frame_ok), 40'd1);
    check("t2_time_o", time_o, lit(40'hA5_0A_14_1E_3C));
    check("t2_locked", 40'(locked), 40'd1);
    repeat (9) @(negedge clk);
    check("t2_no_tick_yet", 40'(sec_tick), 40'd0);
    @(negedge clk);
    check("t2_tick", 40'(sec_tick), 40'd1);
    check("t2_time_o_inc", time_o, lit(40'hA5_0A_14_1F_3D));

    // 3: midnight rollover
    send(40'hA5_17_3B_3A_8C);
    check("t3_time_o", time_o, lit(40'hA5_17_3B_3A_8C));
    repeat (10) @(negedge clk);
    check("t3_2359_59", time_o, lit(40'hA5_17_3B_3B_8D));
    repeat (10) @(negedge clk);
    check("t3_midnight", time_o, lit(40'hA5_00_00_00_00));

    // 4: rejections
    send(40'hA5_0A_14_1E_3D);
    check("t4_badchk_err", 40'(frame_err), 40'(ChkOn));
    check("t4_badchk_ok", 40'(frame_ok), 40'(1 - ChkOn));
    check("t4_badchk_cnt", 40'(err_cnt), 40'(ChkOn));
    if (ChkOn == 0) check("t4_nochk_time", time_o, 40'hA5_0A_14_1E_00);
    send(40'hA5_18_00_00_18);
    check("t4_h24_err", 40'(frame_err), 40'd1);
    check("t4_h24_cnt", 40'(err_cnt), 40'(ChkOn + 1));
    send(40'h5A_0A_14_1E_3C);
    check("t4_hdr_err", 40'(frame_err), 40'd1);
    check("t4_hdr_cnt", 40'(err_cnt), 40'(ChkOn + 2));
    check("t4_locked", 40'(locked), 40'd1);

    // 5: staleness, recovery and prescaler realignment
    send(40'hA5_01_02_03_06);
    check("t5_stale0", 40'(stale), 40'd0);
    repeat (29) @(negedge clk);
    check("t5_not_stale", 40'(stale), 40'd0);
    @(negedge clk);
    check("t5_stale", 40'(stale), 40'd1);
    check("t5_time_o", time_o, lit(40'hA5_01_02_06_09));
    // Load lands exactly on the next tick edge: tick is lost.
    repeat (8) @(negedge clk);
    send(40'hA5_01_02_03_06);
    check("t5_reload_ok", 40'(frame_ok), 40'd1);
    check("t5_lost_tick", 40'(sec_tick), 40'd0);
    check("t5_unstale", 40'(stale), 40'd0);
    repeat (9) @(negedge clk);
    check("t5_phase_early", 40'(sec_tick), 40'd0);
    @(negedge clk);
    check("t5_phase_tick", 40'(sec_tick), 40'd1);
    check("t5_time_o2", time_o, lit(40'hA5_01_02_04_07));

    // frame_vld held into CHECK: second frame ignored and not counted
    frame_dat = 40'hA5_02_03_04_09;
    frame_vld = 1'b1;
    @(negedge clk);
    frame_dat = 40'h5A_00_00_00_00;
    @(negedge clk);
    frame_vld = 1'b0;
    check("t5_hold_ok", 40'(frame_ok), 40'd1);
    check("t5_hold_time", time_o, lit(40'hA5_02_03_04_09));
    @(negedge clk);
    check("t5_ignored_err", 40'(frame_err), 40'd0);
    check("t5_ignored_cnt", 40'(err_cnt), 40'(ChkOn + 2));

    // 6: async reset mid-run, frame on the first edge after release
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_time", time_o, 40'hA5_00_00_00_00);
    check("t6_rst_locked", 40'(locked), 40'd0);
    check("t6_rst_cnt", 40'(err_cnt), 40'd0);
    check("t6_rst_stale", 40'(stale), 40'd0);
    @(negedge clk);
    rst = 1'b0;
    send(40'hA5_0A_14_1E_3C);
    check("t6_ok", 40'(frame_ok), 40'd1);
    check("t6_locked", 40'(locked), 40'd1);
    check("t6_time_o", time_o, lit(40'hA5_0A_14_1E_3C));

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
